cdc_hs_rx: RTL and testbench
============================

# cdc_hs_rx

Receiving end of the four-phase req/ack handshake that carries words from the clk_a domain into the clk_b domain of `top`. The block synchronizes the incoming request and captures the data word, which the sender holds stable. It checks parity and presents the word on a valid/ready port to clk_b logic. It returns an acknowledge that the sender resynchronizes. Acknowledge is withheld until the downstream side accepts, so backpressure reaches the sender.

## Interface
- DATA_W, 8, payload width
- SYNC_STAGES, 2, flops in the req synchronizer (legal values ≥ 2)
- CNT_W, 16, width of the transfer and error counters
- PARITY_EN, 1: 1 checks parity; 0 ignores par_a and never flags an error
- clk_b  in  1  sole clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk_b
- req_a  in  1  request from the clk_a domain; asynchronous to clk_b; sampled only through the synchronizer
- data_a  in  DATA_W  payload; held stable by the sender while req_a is high and until it sees ack_b high
- par_a  in  1  parity bit; error when (^data_a) != par_a
- ack_b  out  1  registered acknowledge to the clk_a domain
- out_data  out  DATA_W  captured word; holds its value between captures
- out_valid  out  1  out_data is offered to the consumer
- out_ready  in  1  consumer accepts when out_valid && out_ready at a clock edge
- xfer_count  out  CNT_W  words delivered; wraps modulo 2^CNT_W
- err_count  out  CNT_W  parity errors; saturates at all-ones
- busy  out  1  high whenever state != IDLE

## Operation
- Synchronizer: SYNC_STAGES flops, cleared by rst. req_s is the last stage, and only req_s is used by the FSM.
- IDLE:
  - req_s = 1 with no parity error: capture data_a into out_data, set out_valid = 1, go to DELIVER.
  - req_s = 1 with a parity error: leave out_data unchanged, increment err_count (saturating), set ack_b = 1, go to WAIT_LO.
  - req_s = 0: stay in IDLE.
- DELIVER: out_valid stays high until out_valid && out_ready. On that edge: out_valid = 0, ack_b = 1, xfer_count + 1, go to WAIT_LO.
- WAIT_LO: ack_b stays high until req_s = 0. On that edge: ack_b = 0, go to IDLE.
- One word per four-phase cycle. The FSM never re-samples data_a until it has returned to IDLE, so a req_a still high is never double-captured.
- If req_s is already high when reset releases, the word is captured normally. This is safe under four-phase rules because the sender still holds data stable.
- req_a dropping while in DELIVER is a protocol violation. The block ignores it, stays in DELIVER, and goes from WAIT_LO straight to IDLE on the next edge.
- out_ready is ignored outside DELIVER.

## Timing
- Reset values: ack_b = 0, out_valid = 0, out_data = 0, xfer_count = 0, err_count = 0, busy = 0, state = IDLE, synchronizer = 0.
- Reset during any state forces reset values immediately. An in-flight word is lost, and the sender sees ack_b low.
- Request to capture: req_a high before edge k gives req_s high after edge k+SYNC_STAGES−1. The capture edge is k+SYNC_STAGES; out_valid and busy rise there.
- Capture to acknowledge: with out_ready held high, ack_b rises one edge after out_valid rises. The minimum from req_a sampled to ack_b high is SYNC_STAGES+1 edges.
- Parity error path: ack_b rises on the capture edge itself, with no out_valid pulse.
- Release: req_a low before edge j gives ack_b low on edge j+SYNC_STAGES; busy falls on the same edge.
- Back-to-back: a new req_s high is taken from IDLE at the earliest one edge after ack_b falls.
- Counters update on the same edge as the corresponding ack_b rise.
- xfer_count wraps from all-ones to 0.
- err_count holds at all-ones once saturated.

## Test plan
- Single word, out_ready tied high, data 0xA5 with correct parity:
  - out_data = 0xA5, out_valid high for exactly 1 cycle, ack_b rises SYNC_STAGES+1 edges after req_a is sampled, xfer_count = 1.
- Backpressure: out_ready low for 10 cycles after out_valid rises:
  - out_valid and out_data = 0x3C held for all 10 cycles, ack_b stays low, ack_b rises one edge after out_ready goes high.
- Parity error, data 0x01 with par_a = 0:
  - out_valid never asserts, out_data keeps its previous value, err_count = 1, ack_b completes the handshake normally.
- Stream of 20 words, clk_a period 10 ns and clk_b period 14 ns, random out_ready:
  - Received sequence equals the sent sequence with no duplicates or drops, xfer_count = 20.
- Reset asserted while in DELIVER:
  - ack_b, out_valid and busy go to 0 without waiting for a clock.
  - After release with req_a still high, the word is re-captured once and then completes.
- Counter limits with CNT_W = 4:
  - 17 good words give xfer_count = 1 (wrapped).
  - 17 parity errors give err_count = 15 (saturated).

Source files
------------

// File: rtl/cdc_hs_rx.sv
// rtl/cdc_hs_rx.sv - receive side of a four-phase req/ack word transfer into clk_b
//
// Purpose:
//   Takes words from a clk_a-domain sender using a four-phase req/ack handshake.
//   The request is brought into clk_b through a flop synchronizer. The data word
//   is captured directly, because the sender holds it stable while req is high.
//   Each word is parity-checked and offered downstream on a valid/ready port.
//   The acknowledge is held back until the consumer accepts the word, so
//   downstream backpressure reaches the sender.
//
// Ports:
//   clk_b       in   1        sole clock, rising edge
//   rst         in   1        asynchronous active-low reset (released synchronously)
//   req_a       in   1        request from clk_a domain (asynchronous)
//   data_a      in   DATA_W   payload, stable while req_a high until ack_b seen high
//   par_a       in   1        parity bit; error when (^data_a) != par_a
//   ack_b       out  1        registered acknowledge back to clk_a domain
//   out_data    out  DATA_W   captured word, held between captures
//   out_valid   out  1        out_data offered to consumer
//   out_ready   in   1        consumer accepts on out_valid && out_ready
//   xfer_count  out  CNT_W    words delivered, wrapping
//   err_count   out  CNT_W    parity errors, saturating
//   busy        out  1        handshake in progress (state != IDLE)

module cdc_hs_rx #(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16,
   parameter int PARITY_EN   = 1
) (
   input  logic              clk_b,
   input  logic              rst,
   input  logic              req_a,
   input  logic [DATA_W-1:0] data_a,
   input  logic              par_a,
   output logic              ack_b,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  xfer_count,
   output logic [CNT_W-1:0]  err_count,
   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_DELIVER = 2'd1,
      S_WAIT_LO = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [SYNC_STAGES-1:0]  r_sync;
   logic                    r_ack_b;
   logic [DATA_W-1:0]       r_out_data;
   logic                    r_out_valid;
   logic [CNT_W-1:0]        r_xfer_count;
   logic [CNT_W-1:0]        r_err_count;

   logic                    w_req_s;
   logic                    w_par_err;
   logic                    w_capture;
   logic                    w_drop;
   logic                    w_accept;
   logic                    w_release;

   // Request synchronizer; only its last stage is ever looked at.
   always_ff @(posedge clk_b or negedge rst) begin
      if (!rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], req_a};
      end
   end

   assign w_req_s = r_sync[SYNC_STAGES-1];

   // data_a is already settled when req_s is seen high, so it is read directly.
   assign w_par_err = (PARITY_EN != 0) && ((^data_a) != par_a);

   always_ff @(posedge clk_b or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_drop      = 1'b0;
      w_accept    = 1'b0;
      w_release   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_req_s) begin
               if (w_par_err) begin
                  // Bad word: acknowledge at once so the sender moves on.
                  w_drop      = 1'b1;
                  w_state_nxt = S_WAIT_LO;
               end else begin
                  w_capture   = 1'b1;
                  w_state_nxt = S_DELIVER;
               end
            end
         end
         S_DELIVER: begin
            // A req drop here is ignored; WAIT_LO then exits on the next edge.
            if (out_ready) begin
               w_accept    = 1'b1;
               w_state_nxt = S_WAIT_LO;
            end
         end
         S_WAIT_LO: begin
            if (!w_req_s) begin
               w_release   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_b or negedge rst) begin
      if (!rst) begin
         r_ack_b      <= 1'b0;
         r_out_data   <= '0;
         r_out_valid  <= 1'b0;
         r_xfer_count <= '0;
         r_err_count  <= '0;
      end else begin
         if (w_capture) begin
            r_out_data  <= data_a;
            r_out_valid <= 1'b1;
         end
         if (w_accept) begin
            r_out_valid  <= 1'b0;
            r_ack_b      <= 1'b1;
            r_xfer_count <= r_xfer_count + CNT_ONE;
         end
         if (w_drop) begin
            r_ack_b <= 1'b1;
            if (r_err_count != CNT_MAX) begin
               r_err_count <= r_err_count + CNT_ONE;
            end
         end
         if (w_release) begin
            r_ack_b <= 1'b0;
         end
      end
   end

   assign ack_b      = r_ack_b;
   assign out_data   = r_out_data;
   assign out_valid  = r_out_valid;
   assign xfer_count = r_xfer_count;
   assign err_count  = r_err_count;
   assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_cdc_hs_rx.sv
// tb/tb_cdc_hs_rx.sv - self-checking bench for cdc_hs_rx

module tb_cdc_hs_rx;

   localparam int SYNC = 2;

   logic        clk_a = 1'b0;
   logic        clk_b = 1'b0;
   logic        rst;
   logic        req_a;
   logic [7:0]  data_a;
   logic        par_a;
   logic        out_ready;

   logic        ack_b, out_valid, busy;
   logic [7:0]  out_data;
   logic [15:0] xfer_count, err_count;

   logic        ack_b4, out_valid4, busy4;
   logic [7:0]  out_data4;
   logic [3:0]  xfer_count4, err_count4;

   int          checks = 0;
   int          failures = 0;
   logic [7:0]  rx_q[$];
   logic [7:0]  exp_q[$];
   int          rx_idx = 0;
   int          valid_cycles = 0;

   always #5 clk_a = ~clk_a;
   always #7 clk_b = ~clk_b;

   cdc_hs_rx #(.DATA_W(8), .SYNC_STAGES(SYNC), .CNT_W(16), .PARITY_EN(1)) dut (
      .clk_b(clk_b), .rst(rst), .req_a(req_a), .data_a(data_a), .par_a(par_a),
      .ack_b(ack_b), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .xfer_count(xfer_count), .err_count(err_count), .busy(busy)
   );

   cdc_hs_rx #(.DATA_W(8), .SYNC_STAGES(SYNC), .CNT_W(4), .PARITY_EN(1)) dut4 (
      .clk_b(clk_b), .rst(rst), .req_a(req_a), .data_a(data_a), .par_a(par_a),
      .ack_b(ack_b4), .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready),
      .xfer_count(xfer_count4), .err_count(err_count4), .busy(busy4)
   );

   // Monitor: samples just after the falling edge what the next rising edge will see.
   always @(negedge clk_b) begin
      #1;
      if (rst === 1'b1 && out_valid === 1'b1) begin
         valid_cycles++;
         if (out_ready === 1'b1) rx_q.push_back(out_data);
      end
   end

   task automatic pulse_reset();
      @(negedge clk_b);
      rst = 1'b0;
      repeat (2) @(negedge clk_b);
      rst = 1'b1;
   endtask

   // clk_a-side sender: one full four-phase cycle with bounded waits on ack_b.
   task automatic send_word(input logic [7:0] d, input logic p);
      int n;
      n = 0;
      while (ack_b !== 1'b0 && n < 500) begin @(posedge clk_a); n++; end
      checks++;
      if (ack_b !== 1'b0) begin failures++; $display("FAIL send_ack_idle got=%b required=0", ack_b); end
      @(posedge clk_a);
      data_a = d; par_a = p; req_a = 1'b1;
      if (p == ^d) exp_q.push_back(d);
      n = 0;
      while (ack_b !== 1'b1 && n < 500) begin @(posedge clk_a); n++; end
      checks++;
      if (ack_b !== 1'b1) begin failures++; $display("FAIL send_ack_rise got=%b required=1", ack_b); end
      @(posedge clk_a);
      req_a = 1'b0;
      n = 0;
      while (ack_b !== 1'b0 && n < 500) begin @(posedge clk_a); n++; end
      checks++;
      if (ack_b !== 1'b0) begin failures++; $display("FAIL send_ack_fall got=%b required=0", ack_b); end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk_b);
      checks++; if (ack_b !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b required=0", ack_b); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b required=0", out_valid); end
      checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL rst_data got=%h required=00", out_data); end
      checks++; if (xfer_count !== 16'd0) begin failures++; $display("FAIL rst_xfer got=%0d required=0", xfer_count); end
      checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL rst_err got=%0d required=0", err_count); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b required=0", busy); end
      checks++; if ({ack_b4, out_valid4, busy4, out_data4, xfer_count4, err_count4} !== 19'd0) begin
         failures++; $display("FAIL rst_dut4 got=%h required=0", {ack_b4, out_valid4, busy4, out_data4, xfer_count4, err_count4});
      end
      @(negedge clk_b);
      rst = 1'b1;
      repeat (4) @(negedge clk_b);
      checks++; if (busy !== 1'b0 || ack_b !== 1'b0) begin failures++; $display("FAIL rst_idle busy=%b ack=%b required=0 0", busy, ack_b); end
   endtask

   task automatic test_single();
      int n;
      int vbase;
      logic [7:0] e;
      out_ready = 1'b1;
      vbase = valid_cycles;
      @(negedge clk_b);
      data_a = 8'hA5; par_a = ^8'hA5; req_a = 1'b1;
      exp_q.push_back(8'hA5);
      @(posedge clk_b);
      n = 0;
      while (n < 20) begin
         @(posedge clk_b); #1; n++;
         if (ack_b === 1'b1) break;
      end
      checks++; if (n !== SYNC + 1) begin failures++; $display("FAIL single_ack_latency got=%0d required=%0d", n, SYNC + 1); end
      checks++; if (out_data !== 8'hA5) begin failures++; $display("FAIL single_data got=%h required=a5", out_data); end
      checks++; if (xfer_count !== 16'd1) begin failures++; $display("FAIL single_xfer got=%0d required=1", xfer_count); end
      @(negedge clk_b);
      req_a = 1'b0;
      @(posedge clk_b); #1;
      @(posedge clk_b); #1;
      checks++; if (ack_b !== 1'b1) begin failures++; $display("FAIL single_ack_hold got=%b required=1", ack_b); end
      @(posedge clk_b); #1;
      checks++; if (ack_b !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_release ack=%b busy=%b required=0 0", ack_b, busy); end
      checks++; if (valid_cycles - vbase !== 1) begin failures++; $display("FAIL single_valid_cycles got=%0d required=1", valid_cycles - vbase); end
      while (rx_idx < rx_q.size()) begin
         checks++;
         if (exp_q.size() == 0) begin failures++; $display("FAIL single_extra got=%h required=none", rx_q[rx_idx]); end
         else begin e = exp_q.pop_front(); if (rx_q[rx_idx] !== e) begin failures++; $display("FAIL single_word got=%h required=%h", rx_q[rx_idx], e); end end
         rx_idx++;
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL single_missing got=%0d required=0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_backpressure();
      int n;
      logic [7:0] e;
      out_ready = 1'b0;
      @(negedge clk_b);
      data_a = 8'h3C; par_a = ^8'h3C; req_a = 1'b1;
      exp_q.push_back(8'h3C);
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin @(posedge clk_b); #1; n++; end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== 8'h3C || ack_b !== 1'b0) begin
            failures++; $display("FAIL bp_hold cycle=%0d valid=%b data=%h ack=%b required=1 3c 0", i, out_valid, out_data, ack_b);
         end
         @(posedge clk_b); #1;
      end
      @(negedge clk_b);
      out_ready = 1'b1;
      @(posedge clk_b); #1;
      checks++; if (ack_b !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_ack_rise ack=%b valid=%b required=1 0", ack_b, out_valid); end
      @(negedge clk_b);
      req_a = 1'b0;
      n = 0;
      while (ack_b !== 1'b0 && n < 20) begin @(posedge clk_b); #1; n++; end
      checks++; if (ack_b !== 1'b0) begin failures++; $display("FAIL bp_ack_fall got=%b required=0", ack_b); end
      while (rx_idx < rx_q.size()) begin
         checks++;
         if (exp_q.size() == 0) begin failures++; $display("FAIL bp_extra got=%h required=none", rx_q[rx_idx]); end
         else begin e = exp_q.pop_front(); if (rx_q[rx_idx] !== e) begin failures++; $display("FAIL bp_word got=%h required=%h", rx_q[rx_idx], e); end end
         rx_idx++;
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bp_missing got=%0d required=0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_parity_err();
      int n;
      int vbase;
      out_ready = 1'b1;
      vbase = valid_cycles;
      @(negedge clk_b);
      data_a = 8'h01; par_a = 1'b0; req_a = 1'b1;
      @(posedge clk_b);
      n = 0;
      while (n < 20) begin
         @(posedge clk_b); #1; n++;
         if (ack_b === 1'b1) break;
      end
      checks++; if (n !== SYNC) begin failures++; $display("FAIL perr_ack_latency got=%0d required=%0d", n, SYNC); end
      checks++; if (err_count !== 16'd1) begin failures++; $display("FAIL perr_count got=%0d required=1", err_count); end
      checks++; if (out_data !== 8'h3C) begin failures++; $display("FAIL perr_data_kept got=%h required=3c", out_data); end
      @(negedge clk_b);
      req_a = 1'b0;
      n = 0;
      while (ack_b !== 1'b0 && n < 20) begin @(posedge clk_b); #1; n++; end
      checks++; if (ack_b !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL perr_release ack=%b busy=%b required=0 0", ack_b, busy); end
      checks++; if (valid_cycles - vbase !== 0) begin failures++; $display("FAIL perr_no_valid got=%0d required=0", valid_cycles - vbase); end
      checks++; if (xfer_count !== 16'd2) begin failures++; $display("FAIL perr_xfer got=%0d required=2", xfer_count); end
   endtask

   task automatic test_stream();
      bit done;
      logic [7:0] d;
      logic [7:0] e;
      done = 1'b0;
      pulse_reset();
      fork
         begin
            for (int i = 0; i < 20; i++) begin
               d = 8'($urandom_range(0, 255));
               send_word(d, ^d);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(negedge clk_b);
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      @(negedge clk_b);
      out_ready = 1'b1;
      checks++; if (xfer_count !== 16'd20) begin failures++; $display("FAIL stream_xfer got=%0d required=20", xfer_count); end
      checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL stream_err got=%0d required=0", err_count); end
      while (rx_idx < rx_q.size()) begin
         checks++;
         if (exp_q.size() == 0) begin failures++; $display("FAIL stream_extra got=%h required=none", rx_q[rx_idx]); end
         else begin e = exp_q.pop_front(); if (rx_q[rx_idx] !== e) begin failures++; $display("FAIL stream_word got=%h required=%h", rx_q[rx_idx], e); end end
         rx_idx++;
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL stream_missing got=%0d required=0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_reset_deliver();
      int n;
      int vbase;
      logic [7:0] e;
      out_ready = 1'b0;
      @(negedge clk_b);
      data_a = 8'h5A; par_a = ^8'h5A; req_a = 1'b1;
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin @(posedge clk_b); #1; n++; end
      checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL rd_deliver valid=%b busy=%b required=1 1", out_valid, busy); end
      @(negedge clk_b);
      #3;
      rst = 1'b0;
      #1;
      checks++;
      if (ack_b !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00) begin
         failures++; $display("FAIL rd_async ack=%b valid=%b busy=%b data=%h required=0 0 0 00", ack_b, out_valid, busy, out_data);
      end
      @(negedge clk_b);
      out_ready = 1'b1;
      exp_q.push_back(8'h5A);
      vbase = valid_cycles;
      rst = 1'b1;
      n = 0;
      while (ack_b !== 1'b1 && n < 20) begin @(posedge clk_b); #1; n++; end
      checks++; if (ack_b !== 1'b1 || xfer_count !== 16'd1) begin failures++; $display("FAIL rd_recapture ack=%b xfer=%0d required=1 1", ack_b, xfer_count); end
      @(negedge clk_b);
      req_a = 1'b0;
      n = 0;
      while (ack_b !== 1'b0 && n < 20) begin @(posedge clk_b); #1; n++; end
      checks++; if (ack_b !== 1'b0) begin failures++; $display("FAIL rd_ack_fall got=%b required=0", ack_b); end
      checks++; if (valid_cycles - vbase !== 1) begin failures++; $display("FAIL rd_once got=%0d required=1", valid_cycles - vbase); end
      while (rx_idx < rx_q.size()) begin
         checks++;
         if (exp_q.size() == 0) begin failures++; $display("FAIL rd_extra got=%h required=none", rx_q[rx_idx]); end
         else begin e = exp_q.pop_front(); if (rx_q[rx_idx] !== e) begin failures++; $display("FAIL rd_word got=%h required=%h", rx_q[rx_idx], e); end end
         rx_idx++;
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rd_missing got=%0d required=0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_counter_limits();
      logic [7:0] d;
      logic [7:0] e;
      pulse_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         d = 8'($urandom_range(0, 255));
         send_word(d, ^d);
      end
      checks++; if (xfer_count !== 16'd17) begin failures++; $display("FAIL lim_xfer16 got=%0d required=17", xfer_count); end
      checks++; if (xfer_count4 !== 4'd1) begin failures++; $display("FAIL lim_xfer4_wrap got=%0d required=1", xfer_count4); end
      while (rx_idx < rx_q.size()) begin
         checks++;
         if (exp_q.size() == 0) begin failures++; $display("FAIL lim_extra got=%h required=none", rx_q[rx_idx]); end
         else begin e = exp_q.pop_front(); if (rx_q[rx_idx] !== e) begin failures++; $display("FAIL lim_word got=%h required=%h", rx_q[rx_idx], e); end end
         rx_idx++;
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL lim_missing got=%0d required=0", exp_q.size()); exp_q.delete(); end
      for (int i = 0; i < 17; i++) begin
         d = 8'($urandom_range(0, 255));
         send_word(d, ~(^d));
      end
      checks++; if (err_count !== 16'd17) begin failures++; $display("FAIL lim_err16 got=%0d required=17", err_count); end
      checks++; if (err_count4 !== 4'd15) begin failures++; $display("FAIL lim_err4_sat got=%0d required=15", err_count4); end
      checks++; if (xfer_count !== 16'd17) begin failures++; $display("FAIL lim_xfer_after_err got=%0d required=17", xfer_count); end
      checks++; if (rx_q.size() != rx_idx) begin failures++; $display("FAIL lim_err_delivered got=%0d required=%0d", rx_q.size(), rx_idx); end
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b0;
      req_a     = 1'b0;
      data_a    = 8'h00;
      par_a     = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_single();
      test_backpressure();
      test_parity_err();
      test_stream();
      test_reset_deliver();
      test_counter_limits();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
